// File: rtl/debounce_multi_pkg.sv
// Shared helpers for the multi-channel button debouncer.
package debounce_multi_pkg;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_multi_ch.sv
// One button channel: 2-flop sync, tick-sampled stability filter,
// debounced level, press/release pulses and optional one-shot hold pulse.
module debounce_ch
  import debounce_multi_pkg::*;
#(
  parameter int unsigned STABLE     = 3,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int unsigned SW   = clog2_min1(STABLE + 1);
  localparam logic        IDLE = (ACTIVE_LOW != 0);

  logic          r_sync1;
  logic          r_sync2;
  logic [SW-1:0] r_stab;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          w_samp;

  assign w_samp = r_sync2 ^ IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= IDLE;
      r_sync2   <= IDLE;
      r_stab    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (i_tick) begin
        if (w_samp == r_level) begin
          r_stab <= '0;
        end else if (r_stab == SW'(STABLE - 1)) begin
          // Pulses are issued alongside the level flip so they coincide
          // with the first cycle of the new level.
          r_level   <= w_samp;
          r_stab    <= '0;
          r_press   <= w_samp;
          r_release <= ~w_samp;
        end else begin
          r_stab <= r_stab + 1'b1;
        end
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam int unsigned HW = clog2_min1(HOLD_TICKS + 1);

      logic [HW-1:0] r_hold_cnt;
      logic          r_hold;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hold_cnt <= '0;
          r_hold     <= 1'b0;
        end else begin
          r_hold <= 1'b0;
          if (!r_level) begin
            r_hold_cnt <= '0;
          end else if (i_tick && (r_hold_cnt != HW'(HOLD_TICKS))) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
            r_hold     <= (r_hold_cnt == HW'(HOLD_TICKS - 1));
          end
        end
      end

      assign o_hold = r_hold;
    end else begin : g_no_hold
      assign o_hold = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: shared sample-tick divider
// fanned out to CH independent debounce channels.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int unsigned CH         = 4,
  parameter int unsigned DIV        = 6,
  parameter int unsigned STABLE     = 3,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] release_pulse,
  output logic [CH-1:0] hold_pulse,
  output logic          tick
);

  localparam int unsigned DW = clog2_min1(DIV);

  logic [DW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = w_tick;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_ch
      debounce_ch #(
        .STABLE    (STABLE),
        .HOLD_TICKS(HOLD_TICKS),
        .ACTIVE_LOW(ACTIVE_LOW)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (w_tick),
        .i_btn    (btn[g]),
        .o_level  (level[g]),
        .o_press  (press_pulse[g]),
        .o_release(release_pulse[g]),
        .o_hold   (hold_pulse[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: cycle-by-cycle behavioural model
// plus directed scenarios with hand-computed event timing.
module tb_debounce_multi;

  localparam int CH     = 4;
  localparam int DIV    = 6;
  localparam int STABLE = 3;
  localparam int HOLD   = 4;
  localparam int AL     = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn;
  logic [CH-1:0] level, press_pulse, release_pulse, hold_pulse;
  logic          tick;

  debounce_multi #(
    .CH(CH), .DIV(DIV), .STABLE(STABLE), .HOLD_TICKS(HOLD), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .level(level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .hold_pulse(hold_pulse), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Model: sample phase counted from reset, pressed = btn seen two clocks
  // ago, level flips once STABLE consecutive tick samples disagree with it.
  logic [CH-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_hold;
  logic          m_tick;
  int            m_phase;
  int            m_run[CH];
  int            m_held[CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = (AL != 0) ? '1 : '0;
      m_s2 = m_s1;
      m_level = '0; m_press = '0; m_rel = '0; m_hold = '0;
      m_tick = 1'b0; m_phase = 0;
      for (int i = 0; i < CH; i++) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      automatic bit tk = (m_phase == DIV - 1);
      for (int i = 0; i < CH; i++) begin
        automatic bit pressed = m_s2[i] ^ (AL != 0);
        automatic bit old     = m_level[i];
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_hold[i] = 1'b0;
        if (tk) begin
          if (pressed != old) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
              m_level[i] = pressed; m_run[i] = 0;
              if (pressed) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
            end
          end else m_run[i] = 0;
        end
        if (!old) m_held[i] = 0;
        else if (tk && m_held[i] < HOLD) begin
          m_held[i]++;
          if (m_held[i] == HOLD) m_hold[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_phase = (m_phase + 1) % DIV;
      m_tick = (m_phase == DIV - 1);
    end
  end

  // Event log for the directed checks.
  int n_press[CH], n_rel[CH], n_hold[CH];
  int unsigned press_edge[CH], hold_edge[CH];

  task automatic clr();
    for (int i = 0; i < CH; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_hold[i] = 0;
      press_edge[i] = 0; hold_edge[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("level",   level,         m_level);
      chk("press",   press_pulse,   m_press);
      chk("release", release_pulse, m_rel);
      chk("hold",    hold_pulse,    m_hold);
      chk("tick",    tick,          m_tick);
      chk("press_release_excl", press_pulse & release_pulse, 0);
      for (int i = 0; i < CH; i++) begin
        if (press_pulse[i]) begin
          if (n_press[i] == 0) press_edge[i] = edges;
          n_press[i]++;
        end
        if (release_pulse[i]) n_rel[i]++;
        if (hold_pulse[i]) begin
          if (n_hold[i] == 0) hold_edge[i] = edges;
          n_hold[i]++;
        end
      end
    end
  end

  initial begin
    int unsigned e0, r0, k, t;
    clr();
    rst = 1'b1;
    btn = '1;

    // Reset state, then first tick in the sixth clock period after release.
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_hold", hold_pulse, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b0;
    r0 = edges;
    k = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (tick) begin k = edges - r0; break; end
    end
    chk("first_tick_edge", k, DIV - 1);

    // Clean press on channel 0.
    @(negedge clk); clr();
    btn[0] = 1'b0; e0 = edges;
    repeat (40) @(negedge clk);
    chk("clean_press_cnt", n_press[0], 1);
    chk("clean_press_lat_15_20",
        ((press_edge[0] - e0) >= 15 && (press_edge[0] - e0) <= 20) ? 1 : 0, 1);
    chk("clean_level0", level[0], 1);
    chk("clean_others_quiet", n_press[1] + n_press[2] + n_press[3], 0);
    btn[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("clean_release_cnt", n_rel[0], 1);
    chk("clean_level0_low", level[0], 0);

    // Bounce on channel 1: toggles every 5 clocks, never 3 agreeing ticks.
    clr();
    for (int n = 0; n < 8; n++) begin
      btn[1] = ~btn[1];
      repeat (5) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("bounce_no_press", n_press[1], 0);
    chk("bounce_level1", level[1], 0);

    // Hold on channel 2: hold pulse 4 ticks (24 clocks) after the press.
    clr();
    btn[2] = 1'b0;
    repeat (80) @(negedge clk);
    btn[2] = 1'b1;
    repeat (30) @(negedge clk);
    chk("hold_press_cnt", n_press[2], 1);
    chk("hold_pulse_cnt", n_hold[2], 1);
    chk("hold_delay", hold_edge[2] - press_edge[2], 24);
    chk("hold_release_cnt", n_rel[2], 1);

    // Simultaneous presses on channels 0 and 3.
    clr();
    btn[0] = 1'b0; btn[3] = 1'b0;
    repeat (30) @(negedge clk);
    chk("sim_press0", n_press[0], 1);
    chk("sim_press3", n_press[3], 1);
    chk("sim_same_edge", press_edge[3], press_edge[0]);
    btn[0] = 1'b1; btn[3] = 1'b1;
    repeat (60) @(negedge clk);

    // Reset mid-count: press reported 18 edges after release
    // (sync settles by edge 2, ticks land on edges 6, 12, 18).
    clr();
    btn[0] = 1'b0;
    t = 0;
    for (int n = 0; n < 40 && t < 2; n++) begin
      @(posedge clk); #1;
      if (tick) t++;
    end
    chk("midrst_two_ticks", t, 2);
    @(negedge clk);
    chk("midrst_no_early_press", n_press[0], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r0 = edges;
    clr();
    chk("midrst_level_cleared", level[0], 0);
    repeat (30) @(negedge clk);
    chk("midrst_press_cnt", n_press[0], 1);
    chk("midrst_latency", press_edge[0] - r0, 18);
    btn[0] = 1'b1;
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
